// File: rtl/rv_pkg.sv
// Shared RV32I control definitions: opcodes, instruction formats, controller state and
// encodings for the trap cause and PC source select.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {ITYPE_I, ITYPE_S, ITYPE_B, ITYPE_U, ITYPE_J} instr_type_t;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} ctrl_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE, CAUSE_ILLEGAL, CAUSE_SYSTEM, CAUSE_TIMEOUT
  } trap_cause_t;

  typedef enum logic [1:0] {PC_PLUS4, PC_IMM, PC_REG} pc_sel_t;

  // How the next PC is chosen; branches resolve to PC_IMM or PC_PLUS4 in EXEC.
  typedef enum logic [1:0] {KIND_SEQ, KIND_JAL, KIND_JALR, KIND_BRANCH} pc_kind_t;

endpackage

// File: rtl/core_ctrl_fsm_if.sv
// Handshake and control bundle between the sequencer and memories / datapath.
interface core_ctrl_fsm_if;
  logic        imem_req;
  logic        imem_ack;
  logic        decode_en;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  modport master (
    output imem_req, decode_en, dmem_req, dmem_we, rf_we, pc_en, pc_sel, trap, trap_cause,
           instret,
    input  imem_ack, opcode, rd, branch_taken, dmem_ack
  );

  modport slave (
    input  imem_req, decode_en, dmem_req, dmem_we, rf_we, pc_en, pc_sel, trap, trap_cause,
           instret,
    output imem_ack, opcode, rd, branch_taken, dmem_ack
  );
endinterface

// File: rtl/core_ctrl_fsm_opcode_class.sv
// Combinational opcode classifier, reusable by the multicycle and future pipelined control.
module opcode_class
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_mem,
  output logic       is_store,
  output logic       writes_rd,
  output pc_kind_t   pc_sel_kind,
  output logic       illegal,
  output logic       is_system
);

  always_comb begin
    is_mem      = 1'b0;
    is_store    = 1'b0;
    writes_rd   = 1'b0;
    pc_sel_kind = KIND_SEQ;
    illegal     = 1'b0;
    is_system   = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        is_mem    = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: writes_rd = 1'b1;
      OPC_JAL: begin
        writes_rd   = 1'b1;
        pc_sel_kind = KIND_JAL;
      end
      OPC_JALR: begin
        writes_rd   = 1'b1;
        pc_sel_kind = KIND_JALR;
      end
      OPC_BRANCH: pc_sel_kind = KIND_BRANCH;
      OPC_FENCE:  ;
      OPC_SYSTEM: is_system = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multicycle RV32I sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> WB, with sticky traps on
// illegal/system opcodes and memory handshake timeouts.
module core_ctrl_fsm
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  core_ctrl_fsm_if.master  bus
);

  ctrl_state_t state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [31:0] instret_q, instret_d;
  trap_cause_t cause_q, cause_d;
  pc_sel_t pc_sel_q, pc_sel_d;
  logic rf_we_q, rf_we_d;
  logic store_q, store_d;

  logic     is_mem, is_store, writes_rd, illegal, is_system;
  pc_kind_t pc_sel_kind;

  opcode_class u_opcode_class (
    .opcode      (bus.opcode),
    .is_mem      (is_mem),
    .is_store    (is_store),
    .writes_rd   (writes_rd),
    .pc_sel_kind (pc_sel_kind),
    .illegal     (illegal),
    .is_system   (is_system)
  );

  logic expired;
  assign expired = (to_cnt_q == TO_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      to_cnt_q  <= '0;
      instret_q <= '0;
      cause_q   <= CAUSE_NONE;
      pc_sel_q  <= PC_PLUS4;
      rf_we_q   <= 1'b0;
      store_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
      pc_sel_q  <= pc_sel_d;
      rf_we_q   <= rf_we_d;
      store_q   <= store_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    instret_d = instret_q;
    cause_d   = cause_q;
    pc_sel_d  = pc_sel_q;
    rf_we_d   = rf_we_q;
    store_d   = store_q;
    unique case (state_q)
      FETCH: begin
        // An ack arriving in the expiry cycle still wins over the timeout.
        if (bus.imem_ack) begin
          state_d = DECODE;
        end else if (expired) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (illegal) begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (is_system) begin
          state_d = TRAP;
          cause_d = CAUSE_SYSTEM;
        end else begin
          case (pc_sel_kind)
            KIND_JAL:    pc_sel_d = PC_IMM;
            KIND_JALR:   pc_sel_d = PC_REG;
            KIND_BRANCH: pc_sel_d = bus.branch_taken ? PC_IMM : PC_PLUS4;
            default:     pc_sel_d = PC_PLUS4;
          endcase
          rf_we_d = writes_rd && (bus.rd != 5'd0);
          store_d = is_store;
          if (is_mem) begin
            state_d  = MEM;
            to_cnt_d = '0;
          end else begin
            state_d = WB;
          end
        end
      end
      MEM: begin
        if (bus.dmem_ack) begin
          state_d = WB;
        end else if (expired) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      WB: begin
        instret_d = instret_q + 32'd1;
        state_d   = FETCH;
        to_cnt_d  = '0;
      end
      TRAP: state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // Strobes are masked while rst is high so nothing fires during reset.
  always_comb begin
    bus.imem_req   = !rst && (state_q == FETCH);
    bus.decode_en  = !rst && (state_q == DECODE);
    bus.dmem_req   = !rst && (state_q == MEM);
    bus.dmem_we    = !rst && (state_q == MEM) && store_q;
    bus.rf_we      = !rst && (state_q == WB) && rf_we_q;
    bus.pc_en      = !rst && (state_q == WB);
    bus.pc_sel     = pc_sel_q;
    bus.trap       = !rst && (state_q == TRAP);
    bus.trap_cause = rst ? 2'b00 : cause_q;
    bus.instret    = instret_q;
  end

endmodule
